timer_multi_ch: RTL and testbench

TIMER_MULTI_CH -- requirements
Module: timer_multi_ch

---
 rtl/timer_multi_ch.sv | 138 +++++++++++++
 tb/tb_timer_multi_ch.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_multi_ch.sv
// timer_multi_ch: NCH independent up/down timers sharing one free-running prescaler, APB access.
// Define TIMER_IRQ_EN to add the registered per-channel irq output and the TCR[3:2] enables.
`timescale 1ns/1ps

module timer_multi_ch #(
  parameter int WIDTH = 8,
  parameter int NCH   = 2
) (
  input  logic             pclk,
  input  logic             presetn,
  input  logic             psel,
  input  logic             penable,
  input  logic             pwrite,
  input  logic [7:0]       paddr,
  input  logic [WIDTH-1:0] pwdata,
  output logic [WIDTH-1:0] prdata,
  output logic             pready,
  output logic             pslverr
`ifdef TIMER_IRQ_EN
  ,
  output logic [NCH-1:0]   irq
`endif
);

`ifdef TIMER_IRQ_EN
  localparam logic [7:0] TCR_MASK = 8'hFF;
`else
  localparam logic [7:0] TCR_MASK = 8'hF3;
`endif

  logic [3:0]       presc_q;
  logic [3:0]       tick;
  logic [5:0]       chan;
  logic [1:0]       rsel;
  logic             chan_ok;
  logic             wr_en;

  logic [WIDTH-1:0] tdr_q [NCH];
  logic [7:0]       tcr_q [NCH];
  logic [1:0]       tsr_q [NCH];
  logic [1:0]       tsr_d [NCH];
  logic [WIDTH-1:0] cnt_q [NCH];
  logic [WIDTH-1:0] cnt_d [NCH];

  assign chan    = paddr[7:2];
  assign rsel    = paddr[1:0];
  assign chan_ok = ({26'd0, chan} < 32'(NCH));
  assign wr_en   = psel & penable & pwrite & chan_ok;
  assign pready  = 1'b1;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) presc_q <= '0;
    else          presc_q <= presc_q + 4'd1;
  end

  // tick[k] is high for one cycle out of every 2^(k+1)
  assign tick = {&presc_q[3:0], &presc_q[2:0], &presc_q[1:0], presc_q[0]};

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      cnt_d[c] = cnt_q[c];
      tsr_d[c] = tsr_q[c];
      if (wr_en && chan == 6'(c) && rsel == 2'd2)
        tsr_d[c] = tsr_q[c] & pwdata[1:0];
      if (tcr_q[c][7]) begin
        cnt_d[c] = tdr_q[c];
      end else if (tcr_q[c][4] && tick[tcr_q[c][1:0]]) begin
        if (!tcr_q[c][5]) begin
          if (&cnt_q[c]) begin
            tsr_d[c][0] = 1'b1;
            cnt_d[c]    = tcr_q[c][6] ? tdr_q[c] : '0;
          end else begin
            cnt_d[c] = cnt_q[c] + WIDTH'(1);
          end
        end else begin
          if (cnt_q[c] == '0) begin
            tsr_d[c][1] = 1'b1;
            cnt_d[c]    = tcr_q[c][6] ? tdr_q[c] : '1;
          end else begin
            cnt_d[c] = cnt_q[c] - WIDTH'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int c = 0; c < NCH; c++) begin
        tdr_q[c] <= '0;
        tcr_q[c] <= '0;
        tsr_q[c] <= '0;
        cnt_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        cnt_q[c] <= cnt_d[c];
        tsr_q[c] <= tsr_d[c];
        if (wr_en && chan == 6'(c) && rsel == 2'd0) tdr_q[c] <= pwdata;
        if (wr_en && chan == 6'(c) && rsel == 2'd1) tcr_q[c] <= pwdata[7:0] & TCR_MASK;
      end
    end
  end

  always_comb begin
    prdata  = '0;
    pslverr = 1'b0;
    if (presetn && psel) begin
      for (int c = 0; c < NCH; c++) begin
        if (chan == 6'(c)) begin
          case (rsel)
            2'd0:    prdata = tdr_q[c];
            2'd1:    prdata = WIDTH'(tcr_q[c]);
            2'd2:    prdata = WIDTH'(tsr_q[c]);
            default: prdata = cnt_q[c];
          endcase
        end
      end
      pslverr = penable & (~chan_ok | (pwrite & (rsel == 2'd3)));
    end
  end

`ifdef TIMER_IRQ_EN
  logic [NCH-1:0] irq_q;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      irq_q <= '0;
    end else begin
      for (int c = 0; c < NCH; c++)
        irq_q[c] <= (tsr_q[c][0] & tcr_q[c][3]) | (tsr_q[c][1] & tcr_q[c][2]);
    end
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_timer_multi_ch.sv
// Self-checking bench for timer_multi_ch: directed scenarios plus random APB traffic
// compared against an arithmetic reference model of the timer channels.
`timescale 1ns/1ps

module tb_timer_multi_ch;
  localparam int WIDTH = 8;
  localparam int NCH   = 2;
  localparam int MAXV  = (1 << WIDTH) - 1;
`ifdef TIMER_IRQ_EN
  localparam int TCR_MASK = 'hFF;
`else
  localparam int TCR_MASK = 'hF3;
`endif

  logic             pclk    = 1'b0;
  logic             presetn = 1'b0;
  logic             psel    = 1'b0;
  logic             penable = 1'b0;
  logic             pwrite  = 1'b0;
  logic [7:0]       paddr   = '0;
  logic [WIDTH-1:0] pwdata  = '0;
  logic [WIDTH-1:0] prdata;
  logic             pready;
  logic             pslverr;
`ifdef TIMER_IRQ_EN
  logic [NCH-1:0]   irq;
`endif

  timer_multi_ch #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr)
`ifdef TIMER_IRQ_EN
    ,
    .irq     (irq)
`endif
  );

  always #5 pclk = ~pclk;

  int     n_chk = 0;
  int     n_err = 0;
  longint cyc   = 0;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: registers as plain integers, prescaler as a cycle count modulo 16.
  int m_tdr [NCH];
  int m_tcr [NCH];
  int m_tsr [NCH];
  int m_cnt [NCH];
  int m_irq [NCH];
  int m_presc;

  always @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      m_presc = 0;
      for (int c = 0; c < NCH; c++) begin
        m_tdr[c] = 0; m_tcr[c] = 0; m_tsr[c] = 0; m_cnt[c] = 0; m_irq[c] = 0;
      end
    end else begin
      int  wch, wreg, period, setf, cnt;
      bit  wr, tk;
      wch  = int'(paddr[7:2]);
      wreg = int'(paddr[1:0]);
      wr   = psel && penable && pwrite && (wch < NCH);
      for (int c = 0; c < NCH; c++) begin
        m_irq[c] = (((m_tsr[c] & 1) != 0) && ((m_tcr[c] & 8) != 0)) ||
                   (((m_tsr[c] & 2) != 0) && ((m_tcr[c] & 4) != 0)) ? 1 : 0;
        period = 2 << (m_tcr[c] & 3);
        tk     = ((m_presc + 1) % period) == 0;
        setf   = 0;
        cnt    = m_cnt[c];
        if ((m_tcr[c] & 'h80) != 0) begin
          cnt = m_tdr[c];
        end else if (((m_tcr[c] & 'h10) != 0) && tk) begin
          if ((m_tcr[c] & 'h20) != 0) begin
            cnt = cnt - 1;
            if (cnt < 0) begin
              setf = 2;
              cnt  = ((m_tcr[c] & 'h40) != 0) ? m_tdr[c] : MAXV;
            end
          end else begin
            cnt = cnt + 1;
            if (cnt > MAXV) begin
              setf = 1;
              cnt  = ((m_tcr[c] & 'h40) != 0) ? m_tdr[c] : 0;
            end
          end
        end
        m_cnt[c] = cnt;
        if (wr && c == wch && wreg == 2) m_tsr[c] = m_tsr[c] & int'(pwdata[1:0]);
        m_tsr[c] = m_tsr[c] | setf;
        if (wr && c == wch && wreg == 0) m_tdr[c] = int'(pwdata);
        if (wr && c == wch && wreg == 1) m_tcr[c] = int'(pwdata[7:0]) & TCR_MASK;
      end
      m_presc = (m_presc + 1) % 16;
    end
  end

  function automatic int exp_rd(input int ch, input int r);
    if (ch >= NCH) return 0;
    case (r)
      0:       return m_tdr[ch];
      1:       return m_tcr[ch];
      2:       return m_tsr[ch];
      default: return m_cnt[ch];
    endcase
  endfunction

  always @(negedge pclk) begin
    #1;
    check("pready", pready, 1);
`ifdef TIMER_IRQ_EN
    for (int c = 0; c < NCH; c++) check("irq_model", irq[c], m_irq[c]);
`endif
  end

  // Bus tasks are entered just after a negedge and return just after a negedge.
  task automatic apb_write(input int ch, input int r, input int data);
    paddr = 8'((ch << 2) | r); pwdata = WIDTH'(data);
    pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
    @(negedge pclk);
    penable = 1'b1;
    #1;
    check("wr_err", pslverr, (ch >= NCH || r == 3) ? 1 : 0);
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input int ch, input int r, output logic [WIDTH-1:0] d,
                          output logic err, output int e);
    paddr = 8'((ch << 2) | r);
    pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
    @(negedge pclk);
    penable = 1'b1;
    #1;
    d   = prdata;
    err = pslverr;
    e   = exp_rd(ch, r);
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic rd_chk(input int ch, input int r);
    logic [WIDTH-1:0] d;
    logic             err;
    int               e;
    apb_read(ch, r, d, err, e);
    check("rd_model", d, e);
    check("rd_err", err, (ch >= NCH) ? 1 : 0);
  endtask

  task automatic rd_const(input string tag, input int ch, input int r, input int exp);
    logic [WIDTH-1:0] d;
    logic             err;
    int               e;
    apb_read(ch, r, d, err, e);
    check(tag, d, exp);
  endtask

  task automatic all_zero(input string tag);
    for (int c = 0; c < NCH; c++)
      for (int r = 0; r < 4; r++) rd_const(tag, c, r, 0);
  endtask

  initial begin
    logic [WIDTH-1:0] d, prev;
    logic             err;
    int               e, ch, r, data, op;
    longint           start, f1;
    bit               found;

    #20_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] d, prev;
    logic             err;
    int               e, ch, r, data, op;
    longint           start, f1;
    bit               found;

    // reset state, with an access to a bad channel held during reset
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h08;
    #12;
    check("rst_prdata", prdata, 0);
    check("rst_pslverr", pslverr, 0);
`ifdef TIMER_IRQ_EN
    check("rst_irq", irq, 0);
`endif
    @(negedge pclk);
    presetn = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(negedge pclk);
    all_zero("rst_regs");

    // down underflow on ch0
    apb_write(0, 0, 'h10);
    apb_write(0, 1, 'h80);
    apb_write(0, 1, 'h30);
    start = cyc;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 8'h02; found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge pclk); #1;
      if (prdata != 0) found = 1;
    end
    if (!found) check("udf_timeout", 0, 1);
    else begin
      check("udf_time", (cyc - start >= 32 && cyc - start <= 36) ? 1 : 0, 1);
      check("udf_tsr", prdata, 2);
      paddr = 8'h03; #1;
      check("udf_cnt", prdata, 'hFF);
    end
    psel = 1'b0; penable = 1'b0;
    @(negedge pclk);

    // up auto-reload on ch1
    apb_write(1, 0, 'hF0);
    apb_write(1, 1, 'h80);
    apb_write(1, 1, 'h50);
    start = cyc;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 8'h06; found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge pclk); #1;
      if (prdata != 0) found = 1;
    end
    f1 = cyc;
    if (!found) check("ovf_timeout", 0, 1);
    else begin
      check("ovf_time", (f1 - start >= 30 && f1 - start <= 34) ? 1 : 0, 1);
      check("ovf_tsr", prdata, 1);
      paddr = 8'h07; #1;
      check("ovf_reload", prdata, 'hF0);
      prev = prdata; found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
        @(negedge pclk); #1;
        if (prev == 8'hFF && prdata == 8'hF0) found = 1;
        prev = prdata;
      end
      if (!found) check("ovf2_timeout", 0, 1);
      else check("ovf_period", cyc - f1, 32);
    end
    psel = 1'b0; penable = 1'b0;
    @(negedge pclk);

    // flag clearing, then a clear coincident with an underflow tick
    apb_write(1, 1, 'h00);
    apb_write(1, 2, 'h00);
    rd_const("tsr_clr", 1, 2, 0);
    apb_write(0, 0, 'h00);
    apb_write(0, 1, 'h80);
    apb_write(0, 2, 'h00);
    rd_const("tsr0_clr", 0, 2, 0);
    for (int i = 0; i < 40 && m_presc != 0; i++) @(negedge pclk);
    apb_write(0, 1, 'h33);
    for (int i = 0; i < 40 && m_presc != 14; i++) @(negedge pclk);
    apb_write(0, 2, 'h00);
    rd_const("clr_vs_udf", 0, 2, 2);
    rd_const("clr_vs_udf_cnt", 0, 3, 'hFF);

    // error responses
    apb_read(2, 0, d, err, e);
    check("bad_ch_data", d, 0);
    check("bad_ch_err", err, 1);
    apb_write(0, 1, 'h00);
    apb_write(0, 0, 'h3C);
    apb_write(0, 1, 'h80);
    apb_write(0, 1, 'h00);
    apb_write(0, 3, 'h5A);
    rd_const("tcnt_ro", 0, 3, 'h3C);

`ifdef TIMER_IRQ_EN
    apb_write(0, 0, 'h02);
    apb_write(0, 1, 'h80);
    apb_write(0, 2, 'h00);
    apb_write(0, 1, 'h34);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 8'h02; found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge pclk); #1;
      if (prdata != 0) found = 1;
    end
    if (!found) check("irq_timeout", 0, 1);
    else begin
      check("irq_pre", irq[0], 0);
      @(negedge pclk); #1;
      check("irq_set", irq[0], 1);
      check("irq1_quiet", irq[1], 0);
    end
    psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    apb_write(0, 2, 'h00);
    @(negedge pclk); #1;
    check("irq_clr", irq[0], 0);
    @(negedge pclk);
    apb_write(0, 1, 'h00);
`endif

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 9);
      ch = $urandom_range(0, NCH);
      if ($urandom_range(0, 15) == 0) ch = 63;
      r  = $urandom_range(0, 3);
      if (op <= 3) begin
        data = int'($urandom) & MAXV;
        if (r == 1 && $urandom_range(0, 3) != 0) data = data & 'h7F;
        apb_write(ch, r, data);
      end else if (op <= 7) begin
        rd_chk(ch, r);
      end else begin
        repeat ($urandom_range(1, 40)) @(negedge pclk);
      end
    end
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < 4; k++) rd_chk(c, k);

    // reset asserted mid-count
    apb_write(0, 0, 'h80);
    apb_write(0, 1, 'h80);
    apb_write(0, 1, 'h1C);
    apb_write(1, 1, 'h34);
    repeat (30) @(negedge pclk);
    presetn = 1'b0;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h03;
    #1;
    check("midrst_prdata", prdata, 0);
    check("midrst_pslverr", pslverr, 0);
`ifdef TIMER_IRQ_EN
    check("midrst_irq", irq, 0);
`endif
    repeat (3) @(negedge pclk);
    presetn = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(negedge pclk);
    all_zero("midrst_regs");
    repeat (40) @(negedge pclk);
    rd_const("midrst_stopped0", 0, 3, 0);
    rd_const("midrst_stopped1", 1, 3, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
